ram_rw_ctl: RTL and testbench
=============================

Name: ram_rw_ctl

Overview:
Host-side RAM access controller driven by the SPI byte stream. Command bytes (dc_i=0) hold or release the CPU and select one of N_RAM memory regions for write or read. An optional command loads an explicit start address. Data bytes (dc_i=1) are packed into XLEN-wide RAM words on writes and returned as read-back bytes on reads. The block sits between the SPI slave byte interface and the instruction/data RAM write/read ports.

Parameters:
XLEN, 32, RAM word width and address width; must be a multiple of 8. BYTES = XLEN/8 is derived.
N_RAM, 2, number of RAM regions; range 1..8.
RAM_BASE, {32'h0002_0000, 32'h0000_0000}, packed N_RAM*XLEN vector of per-region start word addresses; region k uses [k*XLEN +: XLEN].

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
dc_i  in  1  0 = command byte, 1 = data byte
spi_byte_vld_i  in  1  one-cycle strobe per received byte; strobes are at least 2 cycles apart
spi_byte_data_i  in  8  received byte
cpu_rst_n_o  out  1  CPU reset, active low
ram_wr_sel_o  out  N_RAM  one-hot write region select
ram_rd_sel_o  out  N_RAM  one-hot read region select
ram_rw_addr_o  out  XLEN  word address
ram_wr_byte_en_o  out  BYTES  byte write enable, combinational
ram_wr_data_o  out  XLEN  spi_byte_data_i replicated BYTES times, combinational
ram_rd_data_i  in  XLEN  RAM read data; valid 1 cycle after ram_rw_addr_o changes
spi_tx_byte_o  out  8  read-back byte, registered
spi_tx_vld_o  out  1  one-cycle pulse when spi_tx_byte_o is updated

Behaviour:
- Reset: all outputs 0, including cpu_rst_n_o=0, ram_rw_addr_o=0, spi_tx_byte_o=0. State is IDLE and the byte lane is 0. Reset overrides any in-progress operation.
- States: IDLE, WR, RD, ADDR. The lane counter is 0..BYTES-1. The ADDR byte counter is 0..BYTES-1.
- Command decoding applies on spi_byte_vld_i & !dc_i. Every command aborts ADDR loading.
- 8'h2a CPU_RST: cpu_rst_n=0, all selects cleared, addr=0, lane=0, go to IDLE.
- 8'h2b CPU_RUN: same as CPU_RST but cpu_rst_n=1.
- 8'h2c+2k WR_k (k<N_RAM): cpu_rst_n=0, wr_sel=onehot(k), rd_sel=0, addr=RAM_BASE[k], lane=0, go to WR.
- 8'h2d+2k RD_k (k<N_RAM): as WR_k but sets rd_sel=onehot(k) and wr_sel=0, go to RD.
- 8'h40 ADDR_SET: selects and cpu_rst_n unchanged, ADDR byte counter=0, go to ADDR. The state being returned to (WR, RD or IDLE) is derived from the selects.
- Any other command, including out-of-range k: same action as CPU_RST.
- Data byte handling applies on spi_byte_vld_i & dc_i.
- Data byte in IDLE: ignored, no output change.
- Data byte in ADDR, count i: addr[8i+:8] <= byte, so the address is sent LSB first. Other address bytes are unchanged until written. After byte BYTES-1: lane=0, return to the saved state.
- Data byte in WR: ram_wr_byte_en_o = onehot(lane) in the same cycle as the strobe, and 0 otherwise. Registered update: lane+1. When lane==BYTES-1: lane=0 and addr+1.
- Data byte in RD: spi_tx_byte_o <= ram_rd_data_i[8*lane+:8] and spi_tx_vld_o pulses the next cycle. Lane and address advance as in WR. The received byte value is ignored.
- Address increment wraps modulo 2^XLEN and is not bounded by region size.
- ram_wr_byte_en_o is 0 in every state except WR.
- cpu_rst_n_o stays 0 in WR, RD and ADDR unless CPU_RUN was the last state-changing command.

Test Plan:
- Reset, then send 0x2c followed by 8 data bytes 0x11..0x88 (XLEN=32): addr 0 gets byte_en 0001,0010,0100,1000 with data 0x11..0x44; addr 1 gets 0x55..0x88; final addr=2, lane=0.
- 0x2e then 3 data bytes: wr_sel=2'b10, addr=0x0002_0000, byte_en 0001/0010/0100, addr unchanged at end.
- 0x2d, 0x40, address bytes 0x10,0x00,0x00,0x00, then 4 dummy bytes with ram_rd_data_i=0xDEADBEEF at addr 0x10: spi_tx_byte_o=0xEF,0xBE,0xAD,0xDE, four spi_tx_vld_o pulses, addr=0x11.
- 0x2b: cpu_rst_n_o=1, all selects 0. Data bytes then: no byte_en, no tx_vld.
- 0x2c, 2 data bytes, 0x2a mid-word: selects cleared, addr=0, lane=0. A following data byte is ignored.
- 0x2c with ADDR_SET to 0xFFFFFFFF, then 4 data bytes: addr wraps to 0. A 0x3f command gives CPU_RST behaviour. Assert rst_i mid-write: all outputs 0 on the next edge.

Source files
------------

// File: rtl/ram_rw_ctl.sv
// ram_rw_ctl
// Host-side RAM access controller fed by the SPI slave byte stream.
// Command bytes hold or release the CPU and open one of N_RAM regions for
// writing or reading. Another command loads an explicit start address.
// Data bytes are packed into XLEN-wide words on writes. On reads, data bytes
// clock read-back bytes out of the addressed word, LSB lane first.
module ram_rw_ctl #(
    parameter int                      XLEN     = 32,
    parameter int                      N_RAM    = 2,
    parameter logic [N_RAM*XLEN-1:0]   RAM_BASE = {32'h0002_0000, 32'h0000_0000}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_i,
    input  logic                 spi_byte_vld_i,
    input  logic [7:0]           spi_byte_data_i,
    output logic                 cpu_rst_n_o,
    output logic [N_RAM-1:0]     ram_wr_sel_o,
    output logic [N_RAM-1:0]     ram_rd_sel_o,
    output logic [XLEN-1:0]      ram_rw_addr_o,
    output logic [XLEN/8-1:0]    ram_wr_byte_en_o,
    output logic [XLEN-1:0]      ram_wr_data_o,
    input  logic [XLEN-1:0]      ram_rd_data_i,
    output logic [7:0]           spi_tx_byte_o,
    output logic                 spi_tx_vld_o
);

    localparam int BYTES  = XLEN / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Command byte encodings. Region k write is CMD_REGION0 + 2k.
    // Region k read is CMD_REGION0 + 2k + 1.
    localparam logic [7:0] CMD_CPU_RST  = 8'h2a;
    localparam logic [7:0] CMD_CPU_RUN  = 8'h2b;
    localparam logic [7:0] CMD_REGION0  = 8'h2c;
    localparam logic [7:0] CMD_ADDR_SET = 8'h40;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ADDR
    } state_t;

    state_t               state_reg,     state_next;
    logic [LANE_W-1:0]    lane_reg,      lane_next;
    logic [LANE_W-1:0]    addr_cnt_reg,  addr_cnt_next;
    logic [XLEN-1:0]      addr_reg,      addr_next;
    logic [N_RAM-1:0]     wr_sel_reg,    wr_sel_next;
    logic [N_RAM-1:0]     rd_sel_reg,    rd_sel_next;
    logic                 cpu_rst_n_reg, cpu_rst_n_next;
    logic [7:0]           tx_byte_reg,   tx_byte_next;
    logic                 tx_vld_reg,    tx_vld_next;

    logic                 cmd_strobe;
    logic                 data_strobe;
    logic                 wr_strobe;
    logic [N_RAM-1:0]     wr_cmd_hit;
    logic [N_RAM-1:0]     rd_cmd_hit;
    logic [XLEN-1:0]      region_base;
    logic [7:0]           rd_lane_bytes [BYTES];
    state_t               ret_state;

    assign cmd_strobe  = spi_byte_vld_i & ~dc_i;
    assign data_strobe = spi_byte_vld_i & dc_i;
    assign wr_strobe   = data_strobe && (state_reg == ST_WR);

    // Per-region command match. The region codes are distinct, so at most
    // one bit is set across both vectors.
    genvar gi;
    generate
        for (gi = 0; gi < N_RAM; gi++) begin : g_cmd_decode
            assign wr_cmd_hit[gi] = (spi_byte_data_i == 8'(CMD_REGION0 + 2 * gi));
            assign rd_cmd_hit[gi] = (spi_byte_data_i == 8'(CMD_REGION0 + 2 * gi + 1));
        end
    endgenerate

    // Byte lanes of the read word and the one-hot write strobe per lane.
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lanes
            assign rd_lane_bytes[gi]    = ram_rd_data_i[8*gi +: 8];
            assign ram_wr_byte_en_o[gi] = wr_strobe && (lane_reg == LANE_W'(gi));
        end
    endgenerate

    // Start address of the region named by the current command byte.
    always_comb begin
        region_base = '0;
        for (int k = 0; k < N_RAM; k++) begin
            if (wr_cmd_hit[k] || rd_cmd_hit[k]) begin
                region_base = RAM_BASE[k*XLEN +: XLEN];
            end
        end
    end

    // After an address load, return to the mode implied by the open region.
    always_comb begin
        if (|wr_sel_reg) begin
            ret_state = ST_WR;
        end else if (|rd_sel_reg) begin
            ret_state = ST_RD;
        end else begin
            ret_state = ST_IDLE;
        end
    end

    // Next-state logic: commands first, then data bytes by current mode.
    always_comb begin
        state_next     = state_reg;
        lane_next      = lane_reg;
        addr_cnt_next  = addr_cnt_reg;
        addr_next      = addr_reg;
        wr_sel_next    = wr_sel_reg;
        rd_sel_next    = rd_sel_reg;
        cpu_rst_n_next = cpu_rst_n_reg;
        tx_byte_next   = tx_byte_reg;
        tx_vld_next    = 1'b0;

        if (cmd_strobe) begin
            if (spi_byte_data_i == CMD_ADDR_SET) begin
                // Keep the region and CPU state. Only start collecting
                // address bytes.
                addr_cnt_next = '0;
                state_next    = ST_ADDR;
            end else begin
                // Every other command starts from a clean, CPU-held state.
                // Unknown codes and out-of-range regions stop here.
                state_next     = ST_IDLE;
                lane_next      = '0;
                addr_next      = '0;
                wr_sel_next    = '0;
                rd_sel_next    = '0;
                cpu_rst_n_next = 1'b0;
                if (spi_byte_data_i == CMD_CPU_RUN) begin
                    cpu_rst_n_next = 1'b1;
                end else if (|wr_cmd_hit) begin
                    wr_sel_next = wr_cmd_hit;
                    addr_next   = region_base;
                    state_next  = ST_WR;
                end else if (|rd_cmd_hit) begin
                    rd_sel_next = rd_cmd_hit;
                    addr_next   = region_base;
                    state_next  = ST_RD;
                end
            end
        end else if (data_strobe) begin
            case (state_reg)
                ST_ADDR: begin
                    // Address arrives LSB first. Unwritten bytes keep
                    // their old value.
                    addr_next[8*addr_cnt_reg +: 8] = spi_byte_data_i;
                    if (addr_cnt_reg == LAST_LANE) begin
                        lane_next  = '0;
                        state_next = ret_state;
                    end else begin
                        addr_cnt_next = addr_cnt_reg + LANE_W'(1);
                    end
                end
                ST_WR, ST_RD: begin
                    if (state_reg == ST_RD) begin
                        tx_byte_next = rd_lane_bytes[lane_reg];
                        tx_vld_next  = 1'b1;
                    end
                    // Step through the word's lanes, then move to the next
                    // word. The address wraps freely past the region end.
                    if (lane_reg == LAST_LANE) begin
                        lane_next = '0;
                        addr_next = addr_reg + XLEN'(1);
                    end else begin
                        lane_next = lane_reg + LANE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with synchronous reset. Reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            lane_reg      <= '0;
            addr_cnt_reg  <= '0;
            addr_reg      <= '0;
            wr_sel_reg    <= '0;
            rd_sel_reg    <= '0;
            cpu_rst_n_reg <= 1'b0;
            tx_byte_reg   <= '0;
            tx_vld_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lane_reg      <= lane_next;
            addr_cnt_reg  <= addr_cnt_next;
            addr_reg      <= addr_next;
            wr_sel_reg    <= wr_sel_next;
            rd_sel_reg    <= rd_sel_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
            tx_byte_reg   <= tx_byte_next;
            tx_vld_reg    <= tx_vld_next;
        end
    end

    assign cpu_rst_n_o   = cpu_rst_n_reg;
    assign ram_wr_sel_o  = wr_sel_reg;
    assign ram_rd_sel_o  = rd_sel_reg;
    assign ram_rw_addr_o = addr_reg;
    assign ram_wr_data_o = {BYTES{spi_byte_data_i}};
    assign spi_tx_byte_o = tx_byte_reg;
    assign spi_tx_vld_o  = tx_vld_reg;

endmodule

// File: tb/tb_ram_rw_ctl.sv
// Directed testbench for ram_rw_ctl (XLEN=32, N_RAM=2, default region bases).
module tb_ram_rw_ctl;

    logic        clk;
    logic        rst;
    logic        dc;
    logic        vld;
    logic [7:0]  din;
    logic        cpu_rst_n;
    logic [1:0]  wr_sel;
    logic [1:0]  rd_sel;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_vld;

    int          tests = 0;
    int          fails = 0;
    int          tx_pulses = 0;
    logic        tx_vld_s;
    logic [7:0]  tx_byte_s;

    ram_rw_ctl #(
        .XLEN     (32),
        .N_RAM    (2),
        .RAM_BASE ({32'h0002_0000, 32'h0000_0000})
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dc_i             (dc),
        .spi_byte_vld_i   (vld),
        .spi_byte_data_i  (din),
        .cpu_rst_n_o      (cpu_rst_n),
        .ram_wr_sel_o     (wr_sel),
        .ram_rd_sel_o     (rd_sel),
        .ram_rw_addr_o    (addr),
        .ram_wr_byte_en_o (be),
        .ram_wr_data_o    (wr_data),
        .ram_rd_data_i    (rd_data),
        .spi_tx_byte_o    (tx_byte),
        .spi_tx_vld_o     (tx_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle registered read. Address 0x10 holds 0xDEADBEEF.
    always @(posedge clk) begin
        rd_data <= (addr == 32'h10) ? 32'hDEADBEEF : ~addr;
    end

    // Count read-back pulses.
    always @(negedge clk) begin
        if (tx_vld === 1'b1) tx_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
        $display("[TB] check %-12s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // One byte strobe, entered and left at posedge+1. Two cycles per byte.
    task automatic send(input logic d, input logic [7:0] b, input logic [3:0] exp_be);
        dc  = d;
        din = b;
        vld = 1'b1;
        #2;
        chk("byte_en", {28'd0, be}, {28'd0, exp_be});
        if (d) chk("wr_data", wr_data, {4{b}});
        @(posedge clk);
        #1;
        vld       = 1'b0;
        tx_vld_s  = tx_vld;
        tx_byte_s = tx_byte;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst = 1'b1; dc = 1'b0; vld = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_cpu",   {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_wrsel", {30'd0, wr_sel}, 32'd0);
        chk("rst_rdsel", {30'd0, rd_sel}, 32'd0);
        chk("rst_addr",  addr, 32'd0);
        chk("rst_be",    {28'd0, be}, 32'd0);
        chk("rst_wdata", wr_data, 32'd0);
        chk("rst_tx",    {24'd0, tx_byte}, 32'd0);
        chk("rst_txvld", {31'd0, tx_vld}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write region 0, two words
        send(1'b0, 8'h2c, 4'b0000);
        chk("wr0_sel", {30'd0, wr_sel}, 32'd1);
        chk("wr0_addr", addr, 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 8'(8'h11 * (i + 1)), 4'(1 << (i % 4)));
            if (i == 3) chk("wr0_addr1", addr, 32'd1);
        end
        chk("wr0_addr2", addr, 32'd2);

        // Write region 1, partial word
        send(1'b0, 8'h2e, 4'b0000);
        chk("wr1_sel", {30'd0, wr_sel}, 32'd2);
        chk("wr1_addr", addr, 32'h0002_0000);
        send(1'b1, 8'hA1, 4'b0001);
        send(1'b1, 8'hA2, 4'b0010);
        send(1'b1, 8'hA3, 4'b0100);
        chk("wr1_addr_end", addr, 32'h0002_0000);

        // Read region 0 from explicit address 0x10
        send(1'b0, 8'h2d, 4'b0000);
        chk("rd0_rdsel", {30'd0, rd_sel}, 32'd1);
        chk("rd0_wrsel", {30'd0, wr_sel}, 32'd0);
        send(1'b0, 8'h40, 4'b0000);
        send(1'b1, 8'h10, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        chk("rd0_addr", addr, 32'h10);
        p0 = tx_pulses;
        send(1'b1, 8'h55, 4'b0000);
        chk("rd_vld0", {31'd0, tx_vld_s}, 32'd1);
        chk("rd_byte0", {24'd0, tx_byte_s}, 32'hEF);
        send(1'b1, 8'h55, 4'b0000);
        chk("rd_byte1", {24'd0, tx_byte_s}, 32'hBE);
        send(1'b1, 8'h55, 4'b0000);
        chk("rd_byte2", {24'd0, tx_byte_s}, 32'hAD);
        send(1'b1, 8'h55, 4'b0000);
        chk("rd_vld3", {31'd0, tx_vld_s}, 32'd1);
        chk("rd_byte3", {24'd0, tx_byte_s}, 32'hDE);
        chk("rd_pulses", 32'(tx_pulses - p0), 32'd4);
        chk("rd_addr_end", addr, 32'h11);
        chk("rd_cpu", {31'd0, cpu_rst_n}, 32'd0);

        // CPU run: data bytes have no effect
        send(1'b0, 8'h2b, 4'b0000);
        chk("run_cpu", {31'd0, cpu_rst_n}, 32'd1);
        chk("run_wrsel", {30'd0, wr_sel}, 32'd0);
        chk("run_rdsel", {30'd0, rd_sel}, 32'd0);
        p0 = tx_pulses;
        send(1'b1, 8'h77, 4'b0000);
        send(1'b1, 8'h78, 4'b0000);
        chk("run_pulses", 32'(tx_pulses - p0), 32'd0);

        // CPU reset command in mid-word
        send(1'b0, 8'h2c, 4'b0000);
        chk("wr_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
        send(1'b1, 8'h01, 4'b0001);
        send(1'b1, 8'h02, 4'b0010);
        send(1'b0, 8'h2a, 4'b0000);
        chk("abort_wrsel", {30'd0, wr_sel}, 32'd0);
        chk("abort_addr", addr, 32'd0);
        send(1'b1, 8'h03, 4'b0000);
        chk("idle_addr", addr, 32'd0);
        send(1'b0, 8'h2c, 4'b0000);
        send(1'b1, 8'h04, 4'b0001);

        // Address wrap: set 0xFFFFFFFF in WR mode, then write a full word
        send(1'b0, 8'h2c, 4'b0000);
        send(1'b0, 8'h40, 4'b0000);
        for (int i = 0; i < 4; i++) send(1'b1, 8'hFF, 4'b0000);
        chk("wrap_addr_set", addr, 32'hFFFF_FFFF);
        chk("wrap_wrsel", {30'd0, wr_sel}, 32'd1);
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'hC0 + i), 4'(1 << i));
        chk("wrap_addr", addr, 32'd0);

        // Unknown command and out-of-range region act as CPU reset
        send(1'b0, 8'h2b, 4'b0000);
        chk("run2_cpu", {31'd0, cpu_rst_n}, 32'd1);
        send(1'b0, 8'h3f, 4'b0000);
        chk("unk_cpu", {31'd0, cpu_rst_n}, 32'd0);
        send(1'b0, 8'h2c, 4'b0000);
        send(1'b0, 8'h30, 4'b0000);
        chk("oor_wrsel", {30'd0, wr_sel}, 32'd0);
        chk("oor_addr", addr, 32'd0);

        // Reset in the middle of a write, after a read left tx_byte nonzero
        send(1'b0, 8'h2d, 4'b0000);
        send(1'b0, 8'h40, 4'b0000);
        send(1'b1, 8'h10, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        send(1'b1, 8'h00, 4'b0000);
        chk("pre_rst_tx", {24'd0, tx_byte}, 32'hEF);
        send(1'b0, 8'h2b, 4'b0000);
        send(1'b0, 8'h2c, 4'b0000);
        send(1'b1, 8'h09, 4'b0001);
        din = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_cpu",   {31'd0, cpu_rst_n}, 32'd0);
        chk("mrst_wrsel", {30'd0, wr_sel}, 32'd0);
        chk("mrst_addr",  addr, 32'd0);
        chk("mrst_tx",    {24'd0, tx_byte}, 32'd0);
        chk("mrst_txvld", {31'd0, tx_vld}, 32'd0);
        chk("mrst_be",    {28'd0, be}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 8'h2c, 4'b0000);
        send(1'b1, 8'h0a, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
